layer1_frame_sequencer: RTL and testbench

Frame-level controller for the first convolution/pool stage. It waits for the stage's weight load to finish, then streams one 28×28 image from a pixel buffer into the stage at one pixel per cycle. It then counts the stage's result beats until the expected number have arrived or a timeout expires, and reports completion and status to the top-level inference controller. It sits between the frame buffer (synchronous-read RAM) and the layer-1 block.

---
 rtl/layer1_frame_sequencer.sv | 160 ++++++++++++++++
 tb/tb_layer1_frame_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1_frame_sequencer.sv
// Frame sequencer for layer 1: waits for weights, streams one image from the
// pixel buffer into the stage, then counts result beats until complete or timed out.
module layer1_frame_sequencer #(
  parameter int unsigned IMG_PIXELS  = 784,
  parameter int unsigned EXP_OUTPUTS = 144,
  parameter int unsigned MAX_WAIT    = 1000000,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned CNT_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              weights_ready,
  output logic              pix_rd_en,
  output logic [ADDR_W-1:0] pix_rd_addr,
  input  logic [7:0]        pix_rd_data,
  output logic              l1_valid_in,
  output logic [7:0]        l1_pixel_in,
  input  logic              l1_result_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [7:0]        out_count,
  output logic [15:0]       frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_W,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic              pix_rd_en_q, pix_rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              v1_q, v1_d;
  logic              v2_q, v2_d;
  logic [7:0]        pixel_q, pixel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tout_q, tout_d;
  logic [7:0]        oc_q, oc_d;
  logic [15:0]       fc_q, fc_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              accept_start;
  logic              counting;

  always_comb begin
    state_d      = state_q;
    addr_d       = '0;
    wait_d       = '0;
    tout_d       = tout_q;
    oc_d         = oc_q;
    fc_d         = fc_q;
    v1_d         = pix_rd_en_q;
    v2_d         = v1_q;
    pixel_d      = v1_q ? pix_rd_data : pixel_q;
    accept_start = 1'b0;
    counting     = (state_q == S_FEED) || (state_q == S_DRAIN) || (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_WAIT_W;
          accept_start = 1'b1;
        end
      end
      S_WAIT_W: begin
        if (weights_ready) state_d = S_FEED;
      end
      S_FEED: begin
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else addr_d = addr_q + 1'b1;
      end
      S_DRAIN: begin
        wait_d = wait_q + 1'b1;
        // Normal completion takes precedence if both conditions land in the same cycle.
        if (!v1_q && !v2_q && (32'(oc_q) >= EXP_OUTPUTS)) begin
          state_d = S_DONE;
          fc_d    = fc_q + 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_DONE;
          tout_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (counting && l1_result_valid && (oc_q != '1)) oc_d = oc_q + 1'b1;

    if (accept_start) begin
      oc_d   = '0;
      tout_d = 1'b0;
    end

    // Abort overrides every transition and flushes the read pipeline.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = '0;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      fc_d    = fc_q;
      tout_d  = tout_q;
    end

    pix_rd_en_d = (state_d == S_FEED);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_rd_en_q <= 1'b0;
      addr_q      <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      pixel_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
      oc_q        <= '0;
      fc_q        <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      pix_rd_en_q <= pix_rd_en_d;
      addr_q      <= addr_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      pixel_q     <= pixel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tout_q      <= tout_d;
      oc_q        <= oc_d;
      fc_q        <= fc_d;
      wait_q      <= wait_d;
    end
  end

  assign pix_rd_en   = pix_rd_en_q;
  assign pix_rd_addr = addr_q;
  assign l1_valid_in = v2_q;
  assign l1_pixel_in = pixel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = tout_q;
  assign out_count   = oc_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_layer1_frame_sequencer.sv
// Directed bench for layer1_frame_sequencer: a table of single-cycle vectors
// followed by whole-frame sequences (nominal, weight wait, timeout, abort, reset).
module tb_layer1_frame_sequencer;

  localparam int unsigned MAXW = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        weights_ready = 1'b0;
  logic        pix_rd_en;
  logic [9:0]  pix_rd_addr;
  logic [7:0]  pix_rd_data = '0;
  logic        l1_valid_in;
  logic [7:0]  l1_pixel_in;
  logic        l1_result_valid = 1'b0;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [7:0]  out_count;
  logic [15:0] frame_count;

  layer1_frame_sequencer #(
    .IMG_PIXELS (784),
    .EXP_OUTPUTS(144),
    .MAX_WAIT   (MAXW),
    .ADDR_W     (10),
    .CNT_W      (20)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .weights_ready  (weights_ready),
    .pix_rd_en      (pix_rd_en),
    .pix_rd_addr    (pix_rd_addr),
    .pix_rd_data    (pix_rd_data),
    .l1_valid_in    (l1_valid_in),
    .l1_pixel_in    (l1_pixel_in),
    .l1_result_valid(l1_result_valid),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .out_count      (out_count),
    .frame_count    (frame_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  int cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pix_rd_en) pix_rd_data <= mem[pix_rd_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit st; bit ab; bit wr; bit rv;
    bit e_busy; bit e_en; int e_addr; bit e_valid; int e_pix; int e_oc;
  } vec_t;

  vec_t vecs [12];

  // Frame statistics collected by run_frame
  int beats, pix_err, gaps, done_cnt, drain_cyc, done_cyc, last_valid_cyc;
  int tout_at_done, fc_at_done, oc_at_done;

  task automatic run_frame(input int n_beats, input bit extra_start, input int budget);
    int injected;
    bit seen_en;
    injected = 0;
    seen_en = pix_rd_en;
    beats = 0; pix_err = 0; gaps = 0; done_cnt = 0;
    drain_cyc = -1; done_cyc = -1; last_valid_cyc = -1;
    tout_at_done = -1; fc_at_done = -1; oc_at_done = -1;
    for (int k = 0; k < budget; k++) begin
      l1_result_valid = pix_rd_en && (injected < n_beats);
      if (l1_result_valid) injected++;
      start = extra_start && (k == 50);
      step();
      start = 1'b0;
      l1_result_valid = 1'b0;
      if (l1_valid_in) begin
        if (l1_pixel_in != 8'(beats)) pix_err++;
        if (beats > 0 && last_valid_cyc != cyc - 1) gaps++;
        beats++;
        last_valid_cyc = cyc;
      end
      if (pix_rd_en) seen_en = 1'b1;
      else if (seen_en && drain_cyc < 0) drain_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        tout_at_done = int'(timeout_err);
        fc_at_done = int'(frame_count);
        oc_at_done = int'(out_count);
      end
      if (done_cnt > 0 && cyc >= done_cyc + 4) break;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int viol, seen_done, seen_valid, reached;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    //            st ab wr rv | busy en addr valid pix oc
    vecs[0]  = '{0, 0, 0, 1,   0, 0, 0, 0, -1, 0};
    vecs[1]  = '{1, 1, 0, 0,   0, 0, 0, 0, -1, 0};
    vecs[2]  = '{1, 0, 0, 0,   1, 0, 0, 0, -1, 0};
    vecs[3]  = '{0, 0, 0, 1,   1, 0, 0, 0, -1, 0};
    vecs[4]  = '{0, 0, 0, 0,   1, 0, 0, 0, -1, 0};
    vecs[5]  = '{0, 0, 1, 0,   1, 1, 0, 0, -1, 0};
    vecs[6]  = '{0, 0, 1, 0,   1, 1, 1, 0, -1, 0};
    vecs[7]  = '{0, 0, 1, 1,   1, 1, 2, 1,  0, 1};
    vecs[8]  = '{1, 0, 1, 0,   1, 1, 3, 1,  1, 1};
    vecs[9]  = '{0, 1, 1, 0,   0, 0, 0, 0, -1, 1};
    vecs[10] = '{0, 0, 1, 0,   0, 0, 0, 0, -1, 1};
    vecs[11] = '{0, 0, 1, 1,   0, 0, 0, 0, -1, 1};

    // Reset state
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_en", pix_rd_en, 0);
    check("rst_valid", l1_valid_in, 0);
    check("rst_oc", out_count, 0);
    check("rst_fc", frame_count, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start = vecs[i].st; abort = vecs[i].ab;
      weights_ready = vecs[i].wr; l1_result_valid = vecs[i].rv;
      step();
      start = 1'b0; abort = 1'b0; l1_result_valid = 1'b0;
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("v%0d_en", i), pix_rd_en, vecs[i].e_en);
      check($sformatf("v%0d_addr", i), pix_rd_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), l1_valid_in, vecs[i].e_valid);
      if (vecs[i].e_pix >= 0) check($sformatf("v%0d_pix", i), l1_pixel_in, vecs[i].e_pix);
      check($sformatf("v%0d_oc", i), out_count, vecs[i].e_oc);
      check($sformatf("v%0d_done", i), done, 0);
    end

    // Nominal frame, with an ignored start while busy
    weights_ready = 1'b1;
    do_start();
    check("nom_busy", busy, 1);
    check("nom_wait_en", pix_rd_en, 0);
    check("nom_oc_clr", out_count, 0);
    step();
    check("nom_first_en", pix_rd_en, 1);
    check("nom_first_addr", pix_rd_addr, 0);
    run_frame(144, 1'b1, 3000);
    check("nom_done_cnt", done_cnt, 1);
    check("nom_beats", beats, 784);
    check("nom_pix_err", pix_err, 0);
    check("nom_gaps", gaps, 0);
    check("nom_done_after_last", int'(done_cyc > last_valid_cyc), 1);
    check("nom_tout", tout_at_done, 0);
    check("nom_fc", fc_at_done, 1);
    check("nom_oc", oc_at_done, 144);
    check("nom_idle", busy, 0);

    // Weight wait
    weights_ready = 1'b0;
    do_start();
    viol = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      if (!busy || pix_rd_en) viol++;
    end
    check("ww_hold_viol", viol, 0);
    weights_ready = 1'b1;
    step();
    check("ww_first_en", pix_rd_en, 1);
    check("ww_first_addr", pix_rd_addr, 0);
    run_frame(144, 1'b0, 3000);
    check("ww_done_cnt", done_cnt, 1);
    check("ww_beats", beats, 784);
    check("ww_fc", fc_at_done, 2);

    // Timeout with too few result beats
    do_start();
    run_frame(10, 1'b0, 3000);
    check("to_done_cnt", done_cnt, 1);
    check("to_latency", done_cyc - drain_cyc, int'(MAXW));
    check("to_err", tout_at_done, 1);
    check("to_fc", fc_at_done, 2);
    check("to_oc", oc_at_done, 10);
    l1_result_valid = 1'b1;
    step();
    l1_result_valid = 1'b0;
    check("idle_beat_oc", out_count, 10);
    check("to_sticky", timeout_err, 1);
    do_start();
    check("to_clear", timeout_err, 0);
    check("to_oc_clear", out_count, 0);

    // Abort at pixel 300 of this frame
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (pix_rd_en && pix_rd_addr == 10'd300) begin
        reached = 1;
        break;
      end
    end
    check("ab_reached", reached, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_valid", l1_valid_in, 0);
    check("ab_en", pix_rd_en, 0);
    check("ab_busy", busy, 0);
    seen_done = 0; seen_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) seen_done++;
      if (l1_valid_in) seen_valid++;
    end
    check("ab_no_done", seen_done, 0);
    check("ab_no_valid", seen_valid, 0);
    check("ab_fc", frame_count, 2);
    do_start();
    run_frame(144, 1'b0, 3000);
    check("ab_next_done", done_cnt, 1);
    check("ab_next_beats", beats, 784);
    check("ab_next_pix", pix_err, 0);
    check("ab_next_fc", fc_at_done, 3);

    // Asynchronous reset in DRAIN
    do_start();
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      bit was_en;
      was_en = pix_rd_en;
      step();
      if (was_en && !pix_rd_en) begin
        reached = 1;
        break;
      end
    end
    check("ar_reached_drain", reached, 1);
    #3 rst = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_en", pix_rd_en, 0);
    check("ar_addr", pix_rd_addr, 0);
    check("ar_valid", l1_valid_in, 0);
    check("ar_pix", l1_pixel_in, 0);
    check("ar_tout", timeout_err, 0);
    check("ar_oc", out_count, 0);
    check("ar_fc", frame_count, 0);
    #2 rst = 1'b0;
    step();
    do_start();
    run_frame(144, 1'b0, 3000);
    check("ar_next_done", done_cnt, 1);
    check("ar_next_beats", beats, 784);
    check("ar_next_fc", fc_at_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
